// File: rtl/dcache_pkg.sv
// Shared types and address-field constants for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int LINE_WORDS  = 4;
    localparam int OFF_LSB     = 1;
    localparam int OFF_BITS    = 2;
    localparam int IDX_LSB     = 3;
    localparam int LINE_ADDR_W = ADDR_W - IDX_LSB;

    // Byte bit 0 is always zero for an accepted request, so it is not kept.
    typedef struct packed {
        logic [ADDR_W-1:1] addr;
        logic [DATA_W-1:0] data;
        logic              wr;
    } req_t;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [LINE_ADDR_W-1:0] line,
                                                    input logic [OFF_BITS-1:0]    word);
        return {line, word, 1'b0};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read of one line, synchronous write.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int TAG_BITS   = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [INDEX_BITS-1:0]               idx,
    output logic [TAG_BITS-1:0]                 rd_tag,
    output logic                                rd_valid,
    output logic                                rd_dirty,
    output logic [LINE_WORDS-1:0][DATA_W-1:0]   rd_line,
    input  logic                                data_we,
    input  logic [OFF_BITS-1:0]                 data_off,
    input  logic [DATA_W-1:0]                   data_wdata,
    input  logic                                tag_we,
    input  logic [TAG_BITS-1:0]                 tag_wdata,
    input  logic                                dirty_set,
    input  logic                                dirty_clr
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [TAG_BITS-1:0]               tag_mem  [LINES];
    logic [LINE_WORDS-1:0][DATA_W-1:0] data_mem [LINES];
    logic [LINES-1:0]                  valid;
    logic [LINES-1:0]                  dirty;

    // Payload arrays carry no reset; only the state bits are cleared.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[idx][data_off] <= data_wdata;
        if (tag_we)  tag_mem[idx]            <= tag_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (tag_we)         valid[idx] <= 1'b1;
            if (dirty_set)      dirty[idx] <= 1'b1;
            else if (dirty_clr) dirty[idx] <= 1'b0;
        end
    end

    assign rd_tag   = tag_mem[idx];
    assign rd_valid = valid[idx];
    assign rd_dirty = dirty[idx];
    assign rd_line  = data_mem[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate direct-mapped D-cache controller with a
// one-word-at-a-time handshaked backing-memory port.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int TAG_BITS   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Rd,
    input  logic               Wr,
    input  logic [ADDR_W-1:0]  Addr,
    input  logic [DATA_W-1:0]  DataIn,
    output logic [DATA_W-1:0]  DataOut,
    output logic               Done,
    output logic               Stall,
    output logic               CacheHit,
    output logic               err,
    output logic               mem_req,
    output logic               mem_wr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata
);

    state_t                          state, state_nx;
    req_t                            req;
    logic [OFF_BITS-1:0]             word_cnt;
    logic                            gap;
    logic                            xfer;
    logic                            hit;
    logic                            bad_req;

    logic [INDEX_BITS-1:0]           idx;
    logic [TAG_BITS-1:0]             tag;
    logic [OFF_BITS-1:0]             off;

    logic [TAG_BITS-1:0]             rd_tag;
    logic                            rd_valid, rd_dirty;
    logic [LINE_WORDS-1:0][DATA_W-1:0] rd_line;
    logic                            data_we, tag_we, dirty_set, dirty_clr;
    logic [OFF_BITS-1:0]             data_off;
    logic [DATA_W-1:0]               data_wdata;

    assign idx = req.addr[IDX_LSB +: INDEX_BITS];
    assign tag = req.addr[ADDR_W-1 -: TAG_BITS];
    assign off = req.addr[OFF_LSB +: OFF_BITS];
    assign hit = rd_valid && (rd_tag == tag);

    assign bad_req = (Rd && Wr) || ((Rd || Wr) && Addr[0]);
    assign Stall   = (state != ST_IDLE);

    // gap forces one idle cycle on mem_req after every completed word.
    assign xfer = mem_ack && !gap && (state == ST_WRITEBACK || state == ST_FILL);

    dcache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_array (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .rd_tag     (rd_tag),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_line    (rd_line),
        .data_we    (data_we),
        .data_off   (data_off),
        .data_wdata (data_wdata),
        .tag_we     (tag_we),
        .tag_wdata  (tag),
        .dirty_set  (dirty_set),
        .dirty_clr  (dirty_clr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            req      <= '0;
            word_cnt <= '0;
            gap      <= 1'b0;
        end else begin
            state <= state_nx;
            gap   <= xfer;
            if (state == ST_IDLE && !bad_req && (Rd ^ Wr))
                req <= '{addr: Addr[ADDR_W-1:1], data: DataIn, wr: Wr};
            if (state == ST_LOOKUP) word_cnt <= '0;
            else if (xfer)          word_cnt <= word_cnt + 2'd1;
        end
    end

    always_comb begin
        state_nx   = state;
        Done       = 1'b0;
        CacheHit   = 1'b0;
        DataOut    = '0;
        err        = 1'b0;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        data_we    = 1'b0;
        data_off   = off;
        data_wdata = req.data;
        tag_we     = 1'b0;
        dirty_set  = 1'b0;
        dirty_clr  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bad_req)       err      = rst;
                else if (Rd ^ Wr)  state_nx = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (hit) begin
                    Done     = 1'b1;
                    CacheHit = 1'b1;
                    if (req.wr) begin
                        data_we   = 1'b1;
                        dirty_set = 1'b1;
                    end else begin
                        DataOut = rd_line[off];
                    end
                    state_nx = ST_IDLE;
                end else if (rd_valid && rd_dirty) begin
                    state_nx = ST_WRITEBACK;
                end else begin
                    state_nx = ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                mem_req   = !gap;
                mem_wr    = 1'b1;
                mem_addr  = word_addr({rd_tag, idx}, word_cnt);
                mem_wdata = rd_line[word_cnt];
                if (xfer && word_cnt == 2'd3) begin
                    dirty_clr = 1'b1;
                    state_nx  = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_req  = !gap;
                mem_addr = word_addr(req.addr[ADDR_W-1:IDX_LSB], word_cnt);
                if (xfer) begin
                    data_we    = 1'b1;
                    data_off   = word_cnt;
                    data_wdata = mem_rdata;
                    if (word_cnt == 2'd3) begin
                        tag_we   = 1'b1;
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                Done = 1'b1;
                if (req.wr) begin
                    data_we   = 1'b1;
                    dirty_set = 1'b1;
                end else begin
                    DataOut = rd_line[off];
                end
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
